alu_checker: RTL and testbench
==============================

# alu_checker

Sequential self-checking scoreboard on the consuming end of the ALU port. It accepts one ALU transaction per cycle (operands, control code, observed result and zero flag) and recomputes the expected result from a built-in golden model. It counts passes and failures, captures the first mismatch, and reports a pass/fail verdict at end of run. It sits beside the `ALU` instance in simulation tops and in the FPGA self-test wrapper, replacing manual `$display` inspection.

## Interface
Parameters:
- CNT_W, 16, width of pass/fail counters

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle pulse; begins a new run and clears counters and capture
- end_req  input  1  one-cycle pulse; no further transactions, finish run
- in_valid  input  1  transaction present on in_* this cycle
- in_ready  output  1  checker accepts transactions (high only in RUN)
- in_a, in_b  input  32  (u32) operands applied to the ALU
- in_cont  input  3  (u3) ALUcont applied
- in_result  input  32  (u32) ALU result observed
- in_zero  input  1  (u1) ALU zero observed
- pass_count, fail_count  output  CNT_W  saturating counters
- err_valid  output  1  sticky; a mismatch was captured this run
- err_a, err_b  output  32  operands of first mismatch
- err_cont  output  3  control code of first mismatch
- err_exp, err_got  output  32  expected and observed result of first mismatch
- busy  output  1  state is RUN or DRAIN
- finished  output  1  state is DONE
- all_pass  output  1  valid when finished: fail_count==0 and pass_count!=0

## Operation
- Encoding from common.svh: `ALU_AND`=000 (A&B), `ALU_OR`=001 (A|B), `ALU_ADD`=010 (A+B, mod 2^32), `ALU_SUB`=110 (A-B, mod 2^32), `ALU_SLT`=111 (signed A<B ? 1 : 0). Codes 011,100,101 are illegal: expected result 0, always counted as fail.
- Expected zero = (expected result == 0). A transaction passes iff in_result==expected and in_zero==expected zero (legal code).
- States: IDLE -> RUN on start; RUN -> DRAIN on end_req; DRAIN -> DONE when pipeline empty; DONE -> RUN on start. start in RUN or DRAIN restarts: pipeline flushed, counters/capture cleared, state RUN.
- Handshake: transaction accepted when in_valid && in_ready. in_valid while in_ready low is dropped, not counted.
- end_req coincident with an accepted transaction: transaction is counted, then DRAIN. end_req outside RUN is ignored. start and end_req together: start wins.
- Counters saturate at 2^CNT_W-1; no wrap.
- Capture: first failing transaction after start loads err_*, sets err_valid; later failures only increment fail_count.

## Timing
- Reset values: state IDLE, in_ready 0, all counters 0, err_* 0, err_valid 0, busy 0, finished 0, all_pass 0.
- Two-stage pipeline: stage 1 registers accepted transaction; stage 2 computes expected value, compares, updates counters/capture. Counter visible 2 cycles after acceptance edge.
- Throughput one transaction per cycle, no bubbles.
- DRAIN lasts exactly 2 cycles when entered with both stages full; finished rises the cycle after the last counter update. all_pass changes only on DONE entry and is 0 outside DONE.
- start: counters read 0 the cycle after the start edge; in-flight stage contents discarded (never counted).
- Reset mid-run: immediate return to IDLE, all outputs to reset values regardless of clock.

## Test plan
- Reset then start; send ADD 0+0 result 0 zero 1, AND 150&50 result 18, SUB 100-50 result 50, OR 1|2 result 3, SUB 10-5 result 5, end_req -> pass_count 5, fail_count 0, finished 1, all_pass 1 two cycles after drain.
- Send SUB 5-5 with result 0 but zero 0 -> fail_count 1, err_valid 1, err_exp 0, err_got 0, err_cont 110; all_pass 0 at DONE.
- SLT A=0xFFFFFFFF, B=1, result 1 -> pass; SLT A=1, B=0xFFFFFFFF, result 1 -> fail, err_exp 0.
- Two failures back-to-back (ADD 1+1 got 3, then OR 4|1 got 0) -> fail_count 2, err_a 1, err_b 1, err_got 3 (first captured only).
- Illegal code 100 with any result, plus in_valid asserted in IDLE -> fail_count 1, IDLE transaction not counted.
- Stream 3 transactions, assert start during the third acceptance -> counters 0 afterwards, in-flight results discarded; then assert reset during RUN -> all outputs 0, state IDLE asynchronously.

Source files
------------

// File: rtl/alu_checker.sv
// ============================================================================
// Module   : alu_checker
// Purpose  : Two-stage self-checking scoreboard for the ALU port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             end_req_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  input  logic [2:0]       in_cont_i,
  input  logic [31:0]      in_result_i,
  input  logic             in_zero_i,
  output logic [CNT_W-1:0] pass_count_o,
  output logic [CNT_W-1:0] fail_count_o,
  output logic             err_valid_o,
  output logic [31:0]      err_a_o,
  output logic [31:0]      err_b_o,
  output logic [2:0]       err_cont_o,
  output logic [31:0]      err_exp_o,
  output logic [31:0]      err_got_o,
  output logic             busy_o,
  output logic             finished_o,
  output logic             all_pass_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [2:0] c_AND = 3'b000;
  localparam logic [2:0] c_OR  = 3'b001;
  localparam logic [2:0] c_ADD = 3'b010;
  localparam logic [2:0] c_SUB = 3'b110;
  localparam logic [2:0] c_SLT = 3'b111;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             w_accept;

  logic             s1_vld_q;
  logic [31:0]      s1_a_q, s1_b_q, s1_res_q;
  logic [2:0]       s1_cont_q;
  logic             s1_zero_q;

  logic [31:0]      w_exp;
  logic             w_legal;
  logic             w_pass;

  logic             s2_vld_q;
  logic             s2_pass_q;
  logic [31:0]      s2_a_q, s2_b_q, s2_exp_q, s2_got_q;
  logic [2:0]       s2_cont_q;

  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             errv_q, errv_d;
  logic [31:0]      erra_q, erra_d, errb_q, errb_d;
  logic [31:0]      errexp_q, errexp_d, errgot_q, errgot_d;
  logic [2:0]       errcont_q, errcont_d;
  logic             allp_q, allp_d;

  // A start in the same cycle as a handshake flushes that transaction too.
  assign w_accept = in_valid_i && (state_q == c_RUN) && !start_i;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= c_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = c_RUN;
    end else begin
      case (state_q)
        c_RUN:   if (end_req_i) state_d = c_DRAIN;
        // Stage 2 retires on the same edge, so only stage 1 must be empty.
        c_DRAIN: if (!s1_vld_q) state_d = c_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    finished_o = 1'b0;
    case (state_q)
      c_RUN:   begin in_ready_o = 1'b1; busy_o = 1'b1; end
      c_DRAIN: busy_o = 1'b1;
      c_DONE:  finished_o = 1'b1;
      default: begin end
    endcase
  end

  // ---------------- Stage 1: capture accepted transaction ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_cont_q <= '0;
      s1_res_q  <= '0;
      s1_zero_q <= 1'b0;
    end else begin
      s1_vld_q <= w_accept;
      if (w_accept) begin
        s1_a_q    <= in_a_i;
        s1_b_q    <= in_b_i;
        s1_cont_q <= in_cont_i;
        s1_res_q  <= in_result_i;
        s1_zero_q <= in_zero_i;
      end
    end
  end

  // ---------------- Golden model ----------------
  always_comb begin
    w_exp   = '0;
    w_legal = 1'b1;
    case (s1_cont_q)
      c_AND:   w_exp = s1_a_q & s1_b_q;
      c_OR:    w_exp = s1_a_q | s1_b_q;
      c_ADD:   w_exp = s1_a_q + s1_b_q;
      c_SUB:   w_exp = s1_a_q - s1_b_q;
      c_SLT:   w_exp = {31'd0, ($signed(s1_a_q) < $signed(s1_b_q))};
      default: begin
        w_exp   = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_pass = w_legal && (s1_res_q == w_exp) && (s1_zero_q == (w_exp == 32'd0));

  // ---------------- Stage 2: registered verdict ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s2_vld_q  <= 1'b0;
      s2_pass_q <= 1'b0;
      s2_a_q    <= '0;
      s2_b_q    <= '0;
      s2_cont_q <= '0;
      s2_exp_q  <= '0;
      s2_got_q  <= '0;
    end else begin
      s2_vld_q <= s1_vld_q && !start_i;
      if (s1_vld_q) begin
        s2_pass_q <= w_pass;
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_cont_q <= s1_cont_q;
        s2_exp_q  <= w_exp;
        s2_got_q  <= s1_res_q;
      end
    end
  end

  // ---------------- Counters and first-mismatch capture ----------------
  always_comb begin
    pass_d    = pass_q;
    fail_d    = fail_q;
    errv_d    = errv_q;
    erra_d    = erra_q;
    errb_d    = errb_q;
    errcont_d = errcont_q;
    errexp_d  = errexp_q;
    errgot_d  = errgot_q;
    if (start_i) begin
      pass_d    = '0;
      fail_d    = '0;
      errv_d    = 1'b0;
      erra_d    = '0;
      errb_d    = '0;
      errcont_d = '0;
      errexp_d  = '0;
      errgot_d  = '0;
    end else if (s2_vld_q) begin
      if (s2_pass_q) begin
        if (pass_q != c_CNT_MAX) pass_d = pass_q + 1'b1;
      end else begin
        if (fail_q != c_CNT_MAX) fail_d = fail_q + 1'b1;
        if (!errv_q) begin
          errv_d    = 1'b1;
          erra_d    = s2_a_q;
          errb_d    = s2_b_q;
          errcont_d = s2_cont_q;
          errexp_d  = s2_exp_q;
          errgot_d  = s2_got_q;
        end
      end
    end
  end

  // Verdict is frozen on DONE entry, using the counts of the final retire.
  always_comb begin
    allp_d = 1'b0;
    if (state_d == c_DONE) begin
      if (state_q != c_DONE) allp_d = (fail_d == '0) && (pass_d != '0);
      else                   allp_d = allp_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pass_q    <= '0;
      fail_q    <= '0;
      errv_q    <= 1'b0;
      erra_q    <= '0;
      errb_q    <= '0;
      errcont_q <= '0;
      errexp_q  <= '0;
      errgot_q  <= '0;
      allp_q    <= 1'b0;
    end else begin
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      errv_q    <= errv_d;
      erra_q    <= erra_d;
      errb_q    <= errb_d;
      errcont_q <= errcont_d;
      errexp_q  <= errexp_d;
      errgot_q  <= errgot_d;
      allp_q    <= allp_d;
    end
  end

  assign pass_count_o = pass_q;
  assign fail_count_o = fail_q;
  assign err_valid_o  = errv_q;
  assign err_a_o      = erra_q;
  assign err_b_o      = errb_q;
  assign err_cont_o   = errcont_q;
  assign err_exp_o    = errexp_q;
  assign err_got_o    = errgot_q;
  assign all_pass_o   = allp_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_checker.sv
// ============================================================================
// Module   : tb_alu_checker
// Purpose  : Directed and randomized bench for alu_checker against a run-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_checker;

  localparam int TB_CNT_W = 4;
  localparam int MAXC     = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset, start, end_req, in_valid, in_zero;
  logic [31:0]         in_a, in_b, in_result;
  logic [2:0]          in_cont;
  logic                in_ready, err_valid, busy, finished, all_pass;
  logic [TB_CNT_W-1:0] pass_count, fail_count;
  logic [31:0]         err_a, err_b, err_exp, err_got;
  logic [2:0]          err_cont;

  alu_checker #(.CNT_W(TB_CNT_W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .end_req_i(end_req),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_cont_i(in_cont),
    .in_result_i(in_result), .in_zero_i(in_zero),
    .pass_count_o(pass_count), .fail_count_o(fail_count),
    .err_valid_o(err_valid), .err_a_o(err_a), .err_b_o(err_b),
    .err_cont_o(err_cont), .err_exp_o(err_exp), .err_got_o(err_got),
    .busy_o(busy), .finished_o(finished), .all_pass_o(all_pass)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Run-level reference: what a run should have reported once it is finished.
  bit          m_run;
  int          m_pass, m_fail;
  bit          m_errv;
  logic [31:0] m_ea, m_eb, m_eexp, m_egot;
  logic [2:0]  m_econt;

  function automatic logic [31:0] golden(input logic [2:0] c, input logic [31:0] a, b,
                                         output bit legal);
    legal = 1'b1;
    case (c)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b110: return a - b;
      3'b111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: begin legal = 1'b0; return 32'd0; end
    endcase
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_errv = 0;
    m_ea = 0; m_eb = 0; m_eexp = 0; m_egot = 0; m_econt = 0;
  endtask

  task automatic send(input bit v, input logic [2:0] c, input logic [31:0] a, b, r,
                      input logic z, input bit st, input bit en);
    bit          legal, ok;
    logic [31:0] e;
    in_valid = v; in_cont = c; in_a = a; in_b = b; in_result = r; in_zero = z;
    start = st; end_req = en;
    @(posedge clk); #1;
    in_valid = 0; start = 0; end_req = 0;
    if (st) begin
      model_clear();
      m_run = 1;
    end else if (m_run) begin
      if (v) begin
        e  = golden(c, a, b, legal);
        ok = legal && (r == e) && (z == (e == 0));
        if (ok) begin
          if (m_pass < MAXC) m_pass++;
        end else begin
          if (m_fail < MAXC) m_fail++;
          if (!m_errv) begin
            m_errv = 1; m_ea = a; m_eb = b; m_econt = c; m_eexp = e; m_egot = r;
          end
        end
      end
      if (en) m_run = 0;
    end
  endtask

  task automatic do_start();
    send(0, 3'b0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 16 && !finished; i++) @(negedge clk);
    if (!finished) chk("done_timeout", 0, 1);
  endtask

  task automatic check_all(input string p);
    @(negedge clk);
    chk({p, ".pass"},  pass_count, m_pass);
    chk({p, ".fail"},  fail_count, m_fail);
    chk({p, ".errv"},  err_valid, m_errv);
    chk({p, ".erra"},  err_a, m_ea);
    chk({p, ".errb"},  err_b, m_eb);
    chk({p, ".econt"}, err_cont, m_econt);
    chk({p, ".eexp"},  err_exp, m_eexp);
    chk({p, ".egot"},  err_got, m_egot);
    chk({p, ".fin"},   finished, 1);
    chk({p, ".allp"},  all_pass, (m_fail == 0 && m_pass != 0));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 4));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      default: return $urandom;
    endcase
  endfunction

  task automatic random_run(input int len);
    logic [2:0]  c;
    logic [31:0] a, b, e, r;
    bit          legal, v;
    logic        z;
    do_start();
    for (int i = 0; i < len; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      e = golden(c, a, b, legal);
      r = ($urandom_range(0, 1) != 0) ? e : $urandom;
      z = ($urandom_range(0, 7) == 0) ? (e != 0) : (e == 0);
      send(v, c, a, b, r, z, 0, i == len - 1);
    end
    wait_done();
    check_all("rand");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; start = 0; end_req = 0; in_valid = 0;
    in_a = 0; in_b = 0; in_cont = 0; in_result = 0; in_zero = 0;
    m_run = 0; model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", in_ready, 0);
    chk("rst.pass",  pass_count, 0);
    chk("rst.fail",  fail_count, 0);
    chk("rst.errv",  err_valid, 0);
    chk("rst.busy",  busy, 0);
    chk("rst.fin",   finished, 0);
    chk("rst.allp",  all_pass, 0);
    @(posedge clk); #1 reset = 0;

    // Traffic and end_req in IDLE must be ignored.
    send(1, 3'b010, 1, 1, 5, 0, 0, 1);
    @(negedge clk);
    chk("idle.busy", busy, 0);
    chk("idle.ready", in_ready, 0);

    // Test 1: five passing transactions, latency and drain timing.
    do_start();
    @(negedge clk);
    chk("t1.ready", in_ready, 1);
    send(1, 3'b010, 0, 0, 0, 1, 0, 0);
    @(negedge clk); chk("t1.lat0", pass_count, 0);
    @(negedge clk); chk("t1.lat1", pass_count, 0);
    @(negedge clk); chk("t1.lat2", pass_count, 1);
    send(1, 3'b000, 150, 50, 18, 0, 0, 0);
    send(1, 3'b110, 100, 50, 50, 0, 0, 0);
    send(1, 3'b001, 1, 2, 3, 0, 0, 0);
    send(1, 3'b110, 10, 5, 5, 0, 0, 1);
    @(negedge clk); chk("t1.dr1.busy", busy, 1); chk("t1.dr1.fin", finished, 0);
    @(negedge clk); chk("t1.dr2.busy", busy, 1); chk("t1.dr2.fin", finished, 0);
    @(negedge clk); chk("t1.done.fin", finished, 1); chk("t1.done.busy", busy, 0);
    check_all("t1");

    // Test 2: zero flag wrong; end_req in DONE ignored.
    do_start();
    send(1, 3'b110, 5, 5, 0, 0, 0, 1);
    wait_done();
    check_all("t2");
    send(0, 3'b0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("t2.endign", finished, 1);

    // Test 3: signed SLT.
    do_start();
    send(1, 3'b111, 32'hFFFF_FFFF, 1, 1, 0, 0, 0);
    send(1, 3'b111, 1, 32'hFFFF_FFFF, 1, 0, 0, 1);
    wait_done();
    check_all("t3");

    // Test 4: back-to-back failures, only first captured.
    do_start();
    send(1, 3'b010, 1, 1, 3, 0, 0, 0);
    send(1, 3'b001, 4, 1, 0, 1, 0, 1);
    wait_done();
    check_all("t4");

    // Test 5: traffic in DONE dropped, illegal code fails.
    send(1, 3'b000, 7, 7, 7, 0, 0, 0);
    do_start();
    send(1, 3'b100, 9, 9, 0, 1, 0, 1);
    wait_done();
    check_all("t5");

    // Randomized runs, the last one long enough to saturate the counters.
    for (int k = 0; k < 4; k++) random_run($urandom_range(1, 12));
    random_run(120);

    // Test 6: restart mid-stream discards in-flight work.
    do_start();
    send(1, 3'b010, 2, 2, 4, 0, 0, 0);
    send(1, 3'b010, 2, 2, 9, 0, 0, 0);
    send(1, 3'b010, 3, 3, 6, 0, 1, 0);
    @(negedge clk);
    chk("t6.pass0", pass_count, 0);
    chk("t6.fail0", fail_count, 0);
    chk("t6.errv0", err_valid, 0);
    repeat (4) @(negedge clk);
    chk("t6.pass1", pass_count, 0);
    chk("t6.fail1", fail_count, 0);
    chk("t6.busy",  busy, 1);
    send(1, 3'b010, 1, 2, 3, 0, 0, 0);
    send(1, 3'b000, 6, 3, 5, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("t6.pass2", pass_count, m_pass);
    chk("t6.fail2", fail_count, m_fail);
    chk("t6.erra2", err_a, m_ea);

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk); #3 reset = 1;
    #1;
    chk("arst.ready", in_ready, 0);
    chk("arst.busy",  busy, 0);
    chk("arst.pass",  pass_count, 0);
    chk("arst.fail",  fail_count, 0);
    chk("arst.errv",  err_valid, 0);
    chk("arst.erra",  err_a, 0);
    chk("arst.egot",  err_got, 0);
    chk("arst.fin",   finished, 0);
    @(posedge clk); #1 reset = 0;
    m_run = 0; model_clear();
    @(negedge clk);
    chk("arst.idle", in_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
